// File: rtl/fifo_stream_reader.sv
// Drains a show-ahead FIFO into a registered valid/ready stream through a 2-entry skid buffer.
// Optional accepted-word counter on word_count when FIFO_STREAM_READER_COUNT_EN is defined.
module fifo_stream_reader #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rd,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready
`ifdef FIFO_STREAM_READER_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] word_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_reg;
    logic [DATA_WIDTH-1:0] main_reg;
    logic [DATA_WIDTH-1:0] skid_reg;
    logic                  valid_reg;
    logic                  push;
    logic                  pop;

    // Pop decision depends only on registered state and the FIFO's registered flag,
    // so out_ready never reaches fifo_rd combinationally.
    assign fifo_rd   = ~reset & ~fifo_empty & (state_reg != FULL);
    assign push      = fifo_rd;
    assign pop       = valid_reg & out_ready;
    assign out_valid = valid_reg;
    assign out_data  = main_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (push) begin
                        main_reg  <= fifo_rdata;
                        state_reg <= HALF;
                        valid_reg <= 1'b1;
                    end
                end
                HALF: begin
                    if (push && pop) begin
                        main_reg <= fifo_rdata;
                    end else if (push) begin
                        skid_reg  <= fifo_rdata;
                        state_reg <= FULL;
                    end else if (pop) begin
                        state_reg <= EMPTY;
                        valid_reg <= 1'b0;
                    end
                end
                FULL: begin
                    // fifo_rd is held low here, so only the downstream side can move
                    if (pop) begin
                        main_reg  <= skid_reg;
                        state_reg <= HALF;
                    end
                end
                default: begin
                    state_reg <= EMPTY;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_STREAM_READER_COUNT_EN
    logic [COUNT_WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (pop) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign word_count = count_reg;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: behavioural FIFO feeding the DUT, order scoreboard on the output.
module tb_fifo_stream_reader;

    logic       clk;
    logic       reset;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       fifo_rd;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
`ifdef FIFO_STREAM_READER_COUNT_EN
    logic [3:0] word_count;
`endif

    fifo_stream_reader #(
        .DATA_WIDTH (8),
        .COUNT_WIDTH(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata),
        .fifo_rd   (fifo_rd),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef FIFO_STREAM_READER_COUNT_EN
        ,
        .word_count(word_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] fifo_q[$];
    logic [7:0] sb_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         rx_count = 0;
    int         rd_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sync_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    // One clock: sample handshakes before the edge, update the FIFO model and scoreboard after it.
    task automatic tick();
        logic       rd_s;
        logic       pop_s;
        logic       rst_s;
        logic [7:0] d_s;
        #2;
        rd_s  = fifo_rd;
        pop_s = out_valid & out_ready;
        rst_s = reset;
        d_s   = out_data;
        check("rd_when_empty", {31'd0, fifo_rd & fifo_empty}, 32'd0);
        @(posedge clk);
        #1;
        if (rst_s) begin
            sb_q.delete();
        end else if (pop_s) begin
            if (sb_q.size() == 0) begin
                check("order_underflow", {24'd0, d_s}, 32'hFFFF_FFFF);
            end else begin
                check("order", {24'd0, d_s}, {24'd0, sb_q[0]});
                void'(sb_q.pop_front());
            end
            rx_count++;
        end
        if (rd_s) begin
            sb_q.push_back(fifo_q[0]);
            void'(fifo_q.pop_front());
            rd_count++;
        end
        sync_fifo();
        #1;
        $display("t=%0t rst=%0b rd=%0b ready=%0b valid=%0b data=%02h", $time, rst_s, rd_s,
                 out_ready, out_valid, out_data);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (!out_valid && fifo_q.size() == 0) break;
            tick();
        end
        check(tag, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        int start_rx;
        int start_rd;
        int fed;

        // 1: reset while the FIFO already holds a word
        reset     = 1'b1;
        out_ready = 1'b0;
        fifo_q.push_back(8'hA5);
        sync_fifo();
        tick();
        tick();
        check("t1_rd_in_reset", {31'd0, fifo_rd}, 32'd0);
        check("t1_valid_in_reset", {31'd0, out_valid}, 32'd0);
        check("t1_data_in_reset", {24'd0, out_data}, 32'd0);
        reset = 1'b0;
        #1;
        check("t1_rd_after_reset", {31'd0, fifo_rd}, 32'd1);
        tick();
        check("t1_valid", {31'd0, out_valid}, 32'd1);
        check("t1_data", {24'd0, out_data}, 32'hA5);
        check("t1_rd_fifo_empty", {31'd0, fifo_rd}, 32'd0);
        out_ready = 1'b1;
        tick();
        check("t1_valid_drained", {31'd0, out_valid}, 32'd0);

        // 2: full-rate streaming
        for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
        sync_fifo();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("t2_valid", {31'd0, out_valid}, 32'd1);
            check("t2_data", {24'd0, out_data}, i);
        end
        check("t2_rd_low_when_empty", {31'd0, fifo_rd}, 32'd0);
        tick();
        check("t2_valid_end", {31'd0, out_valid}, 32'd0);

        // 3: stall fills the skid buffer, release resumes without gaps
        for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
        sync_fifo();
        out_ready = 1'b0;
        start_rd  = rd_count;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_stall_data", {24'd0, out_data}, 32'h01);
        end
        check("t3_pop_count", rd_count - start_rd, 32'd2);
        check("t3_rd_full", {31'd0, fifo_rd}, 32'd0);
        out_ready = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            tick();
            check("t3_valid", {31'd0, out_valid}, 32'd1);
            check("t3_data", {24'd0, out_data}, j + 1);
        end
        drain("t3_drain");

        // 4: random backpressure and random FIFO refill over 256 words
        start_rx = rx_count;
        fed      = 0;
        for (int c = 0; c < 4000; c++) begin
            if (rx_count - start_rx >= 256) break;
            if (fed < 256 && $urandom_range(1, 0) == 1) begin
                fifo_q.push_back(8'($urandom_range(255, 0)));
                fed++;
                sync_fifo();
            end
            out_ready = ($urandom_range(1, 0) == 1);
            tick();
        end
        check("t4_word_total", rx_count - start_rx, 32'd256);
        drain("t4_drain");

        // 5: reset while FULL discards both buffered words
        fifo_q.push_back(8'h10);
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h12);
        sync_fifo();
        out_ready = 1'b0;
        tick();
        tick();
        check("t5_full_data", {24'd0, out_data}, 32'h10);
        check("t5_full_rd", {31'd0, fifo_rd}, 32'd0);
        reset = 1'b1;
        #1;
        check("t5_rd_in_reset", {31'd0, fifo_rd}, 32'd0);
        tick();
        check("t5_valid_after_reset", {31'd0, out_valid}, 32'd0);
        check("t5_fifo_kept_12", {24'd0, fifo_rdata}, 32'h12);
        reset = 1'b0;
        tick();
        check("t5_first_word", {24'd0, out_data}, 32'h12);
        check("t5_valid", {31'd0, out_valid}, 32'd1);
        drain("t5_drain");

`ifdef FIFO_STREAM_READER_COUNT_EN
        // 6: counter wraps after 17 accepted words; stalls do not count
        do_reset();
        check("t6_count_reset", {28'd0, word_count}, 32'd0);
        for (int i = 0; i < 17; i++) fifo_q.push_back(8'(8'h40 + i));
        sync_fifo();
        out_ready = 1'b0;
        tick();
        tick();
        tick();
        check("t6_count_stalled", {28'd0, word_count}, 32'd0);
        out_ready = 1'b1;
        tick();
        tick();
        check("t6_count_two", {28'd0, word_count}, 32'd2);
        drain("t6_drain");
        check("t6_count_wrap", {28'd0, word_count}, 32'd1);
`else
        do_reset();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
